// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory with RISC-V byte/half/word load/store decode.
// Latency: resp_valid rises exactly LATENCY edges after the request accept edge; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until resp_valid && resp_ready.
//
// Ports:
//   clk, rst                 - single clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake; req_we, req_addr, req_wdata, req_funct3 qualify it
//   resp_valid / resp_ready  - response handshake; resp_rdata (extended load data), resp_err
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Access decode, all from the captured request.
  logic [AW-1:0] idx;
  logic          illegal_f3;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          mem_we;

  assign idx          = addr_q[AW+1:2];
  assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  always_comb begin
    illegal_f3 = 1'b0;
    if (we_q) begin
      illegal_f3 = (funct3_q != 3'b000) && (funct3_q != 3'b001) && (funct3_q != 3'b010);
    end else begin
      illegal_f3 = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
    end
  end

  // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word.
  assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign acc_err    = illegal_f3 || misaligned || out_of_range;

  // Out-of-range index is aliased here but the result is discarded by acc_err.
  assign rword = mem[idx];
  assign rbyte = 8'(rword >> {addr_q[1:0], 3'b000});
  assign rhalf = addr_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = 32'h0;
    case (funct3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b010:  load_data = rword;
      3'b100:  load_data = {24'h0, rbyte};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = 32'h0;
    endcase
  end

  // Store data replicated across lanes so byte enables alone pick the target.
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The store commits on the same edge the response appears.
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
          mem_we  = we_q && !acc_err && !rst;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, DEPTH=1024).
// Requests are driven at the falling edge; outputs sampled 1 time unit after the rising edge.
// Each check is an immediate assertion; failures are counted and reported.
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction. hold = cycles resp_ready stays low after resp_valid appears,
  // during which the held response and req_ready are checked every cycle.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                        output logic [31:0] rd, output logic err, output int lat);
    logic rdy;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    rdy        = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    chk({tag, "_ready_at_accept"}, {31'b0, rdy}, 32'd1);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd  = resp_rdata;
    err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, rd);
      chk({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    if (hold > 0) begin
      chk({tag, "_idle_after_release"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_valid_cleared"}, {31'b0, resp_valid}, 32'd0);
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [2:0] f3,
                    input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    access(tag, we, addr, wdata, f3, 0, rd, err, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_err", {31'b0, resp_err}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word store/load
    op("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    op("lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Sub-word loads
    op("lb_13",  1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
    op("lbu_13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    op("lh_10",  1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    op("lhu_12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);

    // Sub-word stores
    op("sb_11",   1'b1, 32'h11, 32'h00000055, 3'b000, 32'h0, 1'b0);
    op("lw_sb",   1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
    op("sh_12",   1'b1, 32'h12, 32'h00001234, 3'b001, 32'h0, 1'b0);
    op("lw_sh",   1'b0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 1'b0);

    // Error requests
    op("err_lw_12",   1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
    op("err_sh_11",   1'b1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0, 1'b1);
    op("err_lw_oor",  1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, 32'h0, 1'b1);
    op("err_f3_011",  1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    op("err_sw_f3_4", 1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1);
    op("lw_after_err", 1'b0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 1'b0);

    // Backpressure: resp_ready low for 5 cycles after resp_valid
    access("bp", 1'b0, 32'h10, 32'h0, 3'b010, 5, rd, err, lat);
    chk("bp_latency", 32'(lat), 32'(LATENCY));
    chk("bp_rdata", rd, 32'h123455EF);

    // Reset during BUSY aborts the store
    op("sw_20", 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h11111111;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    chk("abort_accepted", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_valid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    op("lw_20", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

    // Reset wins over a simultaneous request
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h22222222;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    chk("rst_prio_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_prio_no_valid", {31'b0, resp_valid}, 32'd0);
    end
    op("lw_20_after_prio", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, which is the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, which is the number of cycles from request accept to response; legal range 1..15.
REQ-003 SHALL have input clk, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have input req_valid, 1 bit, asserted by the initiator when a request is present.
REQ-006 SHALL have output req_ready, 1 bit, asserted when the block can accept a request.
REQ-007 SHALL have input req_we, 1 bit, where 1 = store and 0 = load.
REQ-008 SHALL have input req_addr, 32 bits, the byte address.
REQ-009 SHALL have input req_wdata, 32 bits, the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have input req_funct3, 3 bits, the RISC-V load/store funct3.
REQ-011 SHALL have output resp_valid, 1 bit, asserted when a response is present.
REQ-012 SHALL have input resp_ready, 1 bit, asserted by the initiator when it accepts the response.
REQ-013 SHALL have output resp_rdata, 32 bits, the extended load data; 0 for stores and errors.
REQ-014 SHALL have output resp_err, 1 bit, flagging a misaligned, out-of-range or illegal-funct3 request.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP, with exactly one request outstanding at a time.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready.
REQ-017 SHALL, on accept, register we/addr/wdata/funct3, load cnt=LATENCY-1, and go to BUSY; inputs are ignored until the next accept.
REQ-018 SHALL, in BUSY with cnt!=0, decrement cnt each cycle; with cnt==0, perform the access and go to RESP on that edge.
REQ-019 SHALL assert resp_valid exactly LATENCY edges after the accept edge (LATENCY=1: high in the cycle after accept).
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_valid&&resp_ready, then clear resp_valid and go to IDLE.
REQ-021 SHALL accept a new request no earlier than the cycle after the response handshake (no same-cycle turnaround).
REQ-022 SHALL compute word index = addr[31:2], byte lane = addr[1:0], in little-endian order.
REQ-023 SHALL decode loads: 000 lb (sign-extend byte), 001 lh (sign-extend half addr[1]), 010 lw, 100 lbu (zero-extend), 101 lhu (zero-extend); 011/110/111 are illegal.
REQ-024 SHALL decode stores: 000 sb (writes one lane), 001 sh (writes the half selected by addr[1]), 010 sw; all other funct3 values are illegal.
REQ-025 SHALL set resp_err=1 for any of the following, and then SHALL NOT modify storage and SHALL return resp_rdata=0:
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- word index >= DEPTH;
- illegal funct3.
REQ-026 SHALL commit a store on the same edge resp_valid rises; only the selected byte lanes change.
REQ-027 SHALL return rdata for a load issued after a store's response handshake that reflects that store.

Reset
REQ-028 SHALL force, when rst=1 on an edge: state=IDLE, cnt=0, resp_valid=0, resp_err=0, resp_rdata=0, and req_ready=1 from the next cycle.
REQ-029 SHALL, on rst during BUSY, abort the access with no store committed; rst during RESP drops the response.
REQ-030 SHALL NOT reset storage contents; words never written read as undefined.
REQ-031 SHALL give rst priority over a simultaneous req_valid and resp_ready; the request is not accepted.

Verification
REQ-032 SHALL cover, with LATENCY=2: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 SHALL cover sub-word loads on word 0x10=0xDEADBEEF: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-034 SHALL cover sb 0x11 data 0x55 then lw 0x10 -> 0xDEAD55EF; sh 0x12 data 0x1234 then lw 0x10 -> 0x123455EF.
REQ-035 SHALL cover error requests: lw 0x12, sh 0x11, lw 4*DEPTH, and funct3=011 -> each gives err=1, rdata=0; a following lw 0x10 is unchanged at 0x123455EF.
REQ-036 SHALL cover backpressure: resp_ready=0 for 5 cycles -> resp_valid/rdata held stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 SHALL cover reset mid-operation: sw 0x20 data 0x11111111 accepted, rst in the following cycle -> no resp_valid; lw 0x20 returns the prior contents, not 0x11111111.
